// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: boot sequencer for the stack CPU.
// Holds the CPU in reset, loads a length-prefixed, checksummed byte
// image into instruction RAM one word at a time, then releases the CPU.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   rx_data/rx_valid  incoming image byte stream
//   rx_ready          byte accepted when rx_valid & rx_ready at clk edge
//   boot_req          one-cycle pulse, restarts loading from any state
//   imem_addr/wdata   instruction RAM write address and data
//   imem_we           one-cycle write strobe per word
//   cpu_reset         registered CPU reset, low only in RUN
//   busy/done/error   load in progress / image running / image rejected
module cpu_boot_ctrl #(
    parameter int width       = 16,
    parameter int iaddr_width = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   boot_req,
    output logic [iaddr_width-1:0] imem_addr,
    output logic [width-1:0]       imem_wdata,
    output logic                   imem_we,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int unsigned MAXN = 32'd1 << iaddr_width;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             sum_q, sum_d;
    logic [7:0]             len_hi_q, len_hi_d;
    logic [iaddr_width:0]   len_q, len_d;
    logic [7:0]             hi_q, hi_d;
    logic [iaddr_width-1:0] cnt_q, cnt_d;
    logic [iaddr_width-1:0] addr_q, addr_d;
    logic [width-1:0]       wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic        load_st;
    logic        acc;
    logic [15:0] n16;

    assign load_st  = (state_q != S_RUN) && (state_q != S_ERR);
    assign rx_ready = load_st & ~boot_req & ~reset;
    assign acc      = rx_valid & rx_ready;
    assign n16      = {len_hi_q, rx_data};

    always_comb begin
        state_d  = state_q;
        sum_d    = acc ? 8'(sum_q + rx_data) : sum_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;

        if (acc) begin
            unique case (state_q)
                S_LEN_HI: begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (n16 == 16'd0 || 32'(n16) > MAXN) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = n16[iaddr_width:0];
                        state_d = S_DAT_HI;
                    end
                end
                S_DAT_HI: begin
                    hi_d    = rx_data;
                    state_d = S_DAT_LO;
                end
                S_DAT_LO: begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = width'({hi_q, rx_data});
                    // Wraps to 0 after a full-size image; never read then.
                    cnt_d   = cnt_q + 1'b1;
                    if ({1'b0, cnt_q} == len_q - 1'b1) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
                S_CSUM: begin
                    // sum_d already includes the checksum byte.
                    state_d = (sum_d == 8'h00) ? S_RUN : S_ERR;
                end
                default: ;
            endcase
        end

        if (boot_req) begin
            state_d = S_LEN_HI;
            sum_d   = 8'h00;
            cnt_d   = '0;
            addr_d  = '0;
            we_d    = 1'b0;
        end

        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERR);
        busy_d      = (state_d != S_RUN) && (state_d != S_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            sum_q       <= 8'h00;
            len_hi_q    <= 8'h00;
            len_q       <= '0;
            hi_q        <= 8'h00;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign imem_we    = we_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb_cpu_boot_ctrl: directed and randomized image loads for cpu_boot_ctrl,
// checked against an image-level reference model.
module tb_cpu_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        boot_req;
    logic [9:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_we;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    cpu_boot_ctrl #(.width(16), .iaddr_width(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .boot_req   (boot_req),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] stim[$];
    int         exp_addr[$];
    int         exp_data[$];
    int         exp_acc;
    bit         exp_run;

    int  mon_addr[$];
    int  mon_data[$];
    int  dbl_we = 0;
    bit  we_prev = 1'b0;

    always @(negedge clk) begin
        if (imem_we) begin
            mon_addr.push_back(int'(imem_addr));
            mon_data.push_back(int'(imem_wdata));
        end
        if (imem_we && we_prev) dbl_we++;
        we_prev = imem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Image-level model: what a correct loader does with stim.
    task automatic model();
        int n;
        int s;
        exp_addr.delete();
        exp_data.delete();
        exp_run = 1'b0;
        n = int'(stim[0]) * 256 + int'(stim[1]);
        if (n == 0 || n > 1024) begin
            exp_acc = 2;
            return;
        end
        exp_acc = 2 + 2 * n + 1;
        s = 0;
        for (int i = 0; i < exp_acc; i++) s += int'(stim[i]);
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back(int'(stim[2+2*w]) * 256 + int'(stim[3+2*w]));
        end
        exp_run = ((s % 256) == 0);
    endtask

    // Builds an image of n words; a bad image gets checksum + 1.
    task automatic build(input int n, input bit good);
        int s;
        stim.delete();
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) stim.push_back(8'($urandom));
        s = 0;
        foreach (stim[i]) s += int'(stim[i]);
        stim.push_back(8'((256 - (s % 256)) % 256 + (good ? 0 : 1)));
    endtask

    task automatic drive(input int max_gap, output int n_acc);
        int waits;
        int gap;
        n_acc = 0;
        for (int i = 0; i < stim.size(); i++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = stim[i];
            waits    = 0;
            #1;
            while (!rx_ready && waits < 12) begin
                @(negedge clk);
                #1;
                waits++;
            end
            if (!rx_ready) begin
                rx_valid = 1'b0;
                return;
            end
            if (exp_run && n_acc == exp_acc - 1)
                chk("cpu_reset_before_csum", cpu_reset, 1);
            @(negedge clk);
            n_acc++;
            if (exp_run && n_acc == exp_acc)
                chk("cpu_reset_fall", cpu_reset, 0);
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_image(input int max_gap, input string tag);
        int base;
        int nacc;
        int got;
        model();
        // One trailing byte that must never be consumed.
        stim.push_back(8'h5A);
        base = mon_addr.size();
        drive(max_gap, nacc);
        got = mon_addr.size() - base;
        chk({tag, "_accepted"}, nacc, exp_acc);
        chk({tag, "_nwrites"}, got, exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got; i++) begin
            chk({tag, "_waddr"}, mon_addr[base+i], exp_addr[i]);
            chk({tag, "_wdata"}, mon_data[base+i], exp_data[i]);
        end
        chk({tag, "_done"}, done, exp_run);
        chk({tag, "_error"}, error, !exp_run);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, !exp_run);
        chk({tag, "_rx_ready"}, rx_ready, 0);
        chk({tag, "_we_pulse"}, dbl_we, 0);
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    task automatic nominal(input bit good);
        stim.delete();
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        if (!good) stim[6] = 8'h41;
    endtask

    initial begin
        int nacc;
        int base;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        boot_req = 1'b0;
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 1);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rel_rx_ready", rx_ready, 1);
        @(negedge clk);

        nominal(1'b1);
        run_image(0, "nominal");

        pulse_boot();
        nominal(1'b0);
        run_image(0, "badcsum");
        boot_req = 1'b1;
        #1;
        chk("boot_req_blocks_ready", rx_ready, 0);
        @(negedge clk);
        boot_req = 1'b0;
        #1;
        chk("boot_clr_error", error, 0);
        chk("boot_rx_ready", rx_ready, 1);
        chk("boot_busy", busy, 1);
        chk("boot_cpu_reset", cpu_reset, 1);
        @(negedge clk);

        stim = '{8'h00, 8'h00};
        run_image(0, "len0");
        pulse_boot();
        stim = '{8'h04, 8'h01};
        run_image(0, "len1025");
        pulse_boot();
        build(1024, 1'b1);
        run_image(0, "len1024");

        pulse_boot();
        nominal(1'b1);
        run_image(5, "throttled");

        for (int k = 0; k < 6; k++) begin
            pulse_boot();
            build($urandom_range(1, 6), $urandom_range(0, 1) == 1);
            run_image($urandom_range(0, 3), "random");
        end

        pulse_boot();
        stim = '{8'h00, 8'h02, 8'h12};
        exp_run = 1'b0;
        exp_acc = 3;
        drive(0, nacc);
        chk("restart_prefix", nacc, 3);
        base = mon_addr.size();
        rx_valid = 1'b1;
        rx_data  = 8'h34;
        boot_req = 1'b1;
        #1;
        chk("restart_not_ready", rx_ready, 0);
        @(negedge clk);
        boot_req = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("restart_no_write", mon_addr.size() - base, 0);
        chk("restart_busy", busy, 1);
        nominal(1'b1);
        run_image(2, "restart");

        #2;
        reset = 1'b1;
        #1;
        chk("async_cpu_reset", cpu_reset, 1);
        chk("async_busy", busy, 1);
        chk("async_done", done, 0);
        chk("async_rx_ready", rx_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nominal(1'b1);
        run_image(1, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
